// File: rtl/dct_pkg.sv
// Shared types and constants for the 8-point DCT row-pass transpose controller.
package dct_pkg;

  localparam int DCT_N          = 8;
  localparam int IN_WIDTH_DEF   = 8;
  localparam int COEF_WIDTH_DEF = 20;

  // Life cycle of one transpose bank: empty, receiving core rows, ready to drain.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } bank_state_t;

  typedef logic signed [IN_WIDTH_DEF-1:0]   row_t [DCT_N];
  typedef logic signed [COEF_WIDTH_DEF-1:0] col_t [DCT_N];

endpackage

// File: rtl/dct8_tbuf.sv
// Two-bank 8x8 transpose store: written a row at a time, read a column at a time.
module dct8_tbuf
  import dct_pkg::*;
#(
  parameter int COEF_WIDTH = COEF_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic                         wr_bank,
  input  logic [2:0]                   wr_row,
  input  logic signed [COEF_WIDTH-1:0] wr_data [DCT_N],
  input  logic                         rd_bank,
  input  logic [2:0]                   rd_col,
  output logic signed [COEF_WIDTH-1:0] rd_data [DCT_N]
);

  logic signed [COEF_WIDTH-1:0] mem [2][DCT_N][DCT_N];

  // Capture one full core result row into the selected bank/row.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < DCT_N; c++) begin
        mem[wr_bank][wr_row][c] <= wr_data[c];
      end
    end
  end

  // Gather coefficient rd_col from every row of the read bank.
  always_comb begin
    for (int r = 0; r < DCT_N; r++) begin
      rd_data[r] = mem[rd_bank][r][rd_col];
    end
  end

endmodule

// File: rtl/dct8_transpose_ctrl.sv
// Row-pass scheduler for a pipelined 8-point DCT core. Rows are only issued
// into a bank already claimed for their results, because the core cannot stall.
module dct8_transpose_ctrl
  import dct_pkg::*;
#(
  parameter int IN_WIDTH     = IN_WIDTH_DEF,
  parameter int COEF_WIDTH   = COEF_WIDTH_DEF,
  parameter int CORE_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   in_row [0:7],
  output logic                         core_valid_in,
  output logic signed [IN_WIDTH-1:0]   core_x [0:7],
  input  logic                         core_valid_out,
  input  logic signed [COEF_WIDTH-1:0] core_y [0:7],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [COEF_WIDTH-1:0] out_col [0:7],
  output logic [2:0]                   out_col_idx,
  output logic                         out_last,
  output logic                         err
);

  if (CORE_LATENCY < 1) begin : g_bad_latency
    $error("CORE_LATENCY must be at least 1");
  end

  bank_state_t state [2];
  bank_state_t state_next [2];

  logic       ibank, cbank, rbank;
  logic [2:0] irow, crow, rcol;
  logic       accept, cap_ok, cap_bad, rd_fire;

  assign core_x  = in_row;
  assign accept  = core_valid_in;
  assign cap_ok  = core_valid_out && (state[cbank] == FILL);
  assign cap_bad = core_valid_out && (state[cbank] != FILL);
  assign rd_fire = out_valid && out_ready;

  // Register bank states, the three pointer pairs and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state[0] <= FREE;
      state[1] <= FREE;
      ibank    <= 1'b0;
      irow     <= 3'd0;
      cbank    <= 1'b0;
      crow     <= 3'd0;
      rbank    <= 1'b0;
      rcol     <= 3'd0;
      err      <= 1'b0;
    end else begin
      state[0] <= state_next[0];
      state[1] <= state_next[1];
      if (accept) begin
        irow <= irow + 3'd1;
        if (irow == 3'd7) ibank <= ~ibank;
      end
      if (cap_ok) begin
        crow <= crow + 3'd1;
        if (crow == 3'd7) cbank <= ~cbank;
      end
      if (cap_bad) err <= 1'b1;
      if (rd_fire) begin
        rcol <= rcol + 3'd1;
        if (rcol == 3'd7) rbank <= ~rbank;
      end
    end
  end

  // Bank transitions; each needs a different source state, so they never collide.
  always_comb begin
    state_next[0] = state[0];
    state_next[1] = state[1];
    if (accept && (irow == 3'd0)) state_next[ibank] = FILL;
    if (cap_ok && (crow == 3'd7)) state_next[cbank] = FULL;
    if (rd_fire && (rcol == 3'd7)) state_next[rbank] = FREE;
  end

  // Handshake outputs decoded from registered state only, forced low in reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (!rst) begin
      in_ready  = (irow == 3'd0) ? (state[ibank] == FREE) : (state[ibank] == FILL);
      out_valid = (state[rbank] == FULL);
      out_last  = (state[rbank] == FULL) && (rcol == 3'd7);
    end
    core_valid_in = in_valid && in_ready;
    out_col_idx   = rcol;
  end

  dct8_tbuf #(
    .COEF_WIDTH(COEF_WIDTH)
  ) u_tbuf (
    .clk     (clk),
    .we      (cap_ok && !rst),
    .wr_bank (cbank),
    .wr_row  (crow),
    .wr_data (core_y),
    .rd_bank (rbank),
    .rd_col  (rcol),
    .rd_data (out_col)
  );

endmodule

// File: tb/tb_dct8_transpose_ctrl.sv
// Bench for dct8_transpose_ctrl: a 4-cycle sign-extending stub core closes the
// loop, a reference transpose model feeds a column scoreboard, and fixed cycle
// windows check the handshake timing.
module tb_dct8_transpose_ctrl;

  localparam int IW  = 8;
  localparam int CW  = 20;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, core_valid_in, core_valid_out;
  logic                 out_valid, out_ready, out_last, err;
  logic signed [IW-1:0] in_row [0:7];
  logic signed [IW-1:0] core_x [0:7];
  logic signed [CW-1:0] core_y [0:7];
  logic signed [CW-1:0] out_col [0:7];
  logic [2:0]           out_col_idx;

  dct8_transpose_ctrl #(
    .IN_WIDTH(IW), .COEF_WIDTH(CW), .CORE_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .core_valid_in(core_valid_in), .core_x(core_x),
    .core_valid_out(core_valid_out), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_col_idx(out_col_idx), .out_last(out_last), .err(err)
  );

  // Identity stub core: fixed latency, sign extension, shares rst.
  logic                 stub_v [LAT];
  logic signed [IW-1:0] stub_d [LAT][8];
  logic                 inject;
  logic signed [CW-1:0] inject_y [8];

  // Delay line modelling the core pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stub_v[i] <= 1'b0;
    end else begin
      stub_v[0] <= core_valid_in;
      for (int i = 1; i < LAT; i++) stub_v[i] <= stub_v[i-1];
    end
    for (int c = 0; c < 8; c++) begin
      stub_d[0][c] <= core_x[c];
      for (int i = 1; i < LAT; i++) stub_d[i][c] <= stub_d[i-1][c];
    end
  end

  // Core outputs, optionally overridden by a spurious injected result.
  always_comb begin
    core_valid_out = inject | stub_v[LAT-1];
    for (int c = 0; c < 8; c++) begin
      core_y[c] = inject ? inject_y[c] : CW'(stub_d[LAT-1][c]);
    end
  end

  // Scoreboard state
  typedef struct packed {
    logic [7:0][CW-1:0] col;
    logic [2:0]         idx;
  } exp_t;

  exp_t                 exp_q [$];
  logic signed [IW-1:0] blk [8][8];
  int                   nrows = 0;
  int                   ncols = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;

  // Stimulus source state
  int rows_left = 0;
  int src_idx   = 0;
  bit rnd_mode  = 1'b0;
  bit acc_g     = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: collect accepted rows; each complete block yields its
  // eight transposed columns in order.
  always @(negedge clk) begin
    if (rst) begin
      nrows = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      for (int c = 0; c < 8; c++) blk[nrows][c] = in_row[c];
      nrows++;
      if (nrows == 8) begin
        for (int k = 0; k < 8; k++) begin
          exp_t e;
          e.idx = 3'(k);
          for (int r = 0; r < 8; r++) e.col[r] = CW'(blk[r][k]);
          exp_q.push_back(e);
        end
        nrows = 0;
      end
    end
  end

  // Monitor: compare every transferred column against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL column_unexpected: got column %0d, expected none", out_col_idx);
      end else begin
        exp_t e;
        bit   ok;
        int   bad;
        e   = exp_q.pop_front();
        ok  = (out_col_idx == e.idx) && (out_last == (e.idx == 3'd7));
        bad = -1;
        for (int r = 0; r < 8; r++) begin
          if (out_col[r] !== e.col[r]) begin
            ok = 1'b0;
            if (bad < 0) bad = r;
          end
        end
        if (!ok) begin
          n_fail++;
          if (bad < 0) bad = 0;
          $display("[TB] FAIL column_data: got idx %0d last %0b row%0d=%0d, expected idx %0d last %0b row%0d=%0d",
                   out_col_idx, out_last, bad, out_col[bad], e.idx, (e.idx == 3'd7),
                   bad, $signed(e.col[bad]));
        end
      end
      ncols++;
    end
  end

  task automatic new_row();
    for (int c = 0; c < 8; c++) begin
      in_row[c] = rnd_mode ? IW'($urandom) : IW'(8 * (src_idx % 8) + c);
    end
  endtask

  task automatic advance(input bit acc);
    if (acc) begin
      rows_left--;
      src_idx++;
      new_row();
    end
    in_valid = (rows_left > 0);
  endtask

  task automatic half_neg();
    @(negedge clk);
    acc_g = in_valid && in_ready;
  endtask

  task automatic half_pos();
    @(posedge clk);
    #1;
    advance(acc_g);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      half_neg();
      half_pos();
    end
  endtask

  task automatic apply_stimulus(input int n, input bit rnd);
    rows_left = n;
    rnd_mode  = rnd;
    src_idx   = 0;
    new_row();
    in_valid  = (n > 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rows_left = 0;
    in_valid  = 1'b0;
    inject    = 1'b0;
    out_ready = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic check_output(input string name, input int n_cols, input int budget);
    int target;
    int left;
    target = ncols + n_cols;
    left   = budget;
    while (ncols < target && left > 0) begin
      run(1);
      left--;
    end
    chk(name, ncols, target);
  endtask

  // Watchdog so the bench always reaches its summary.
  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int budget;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    inject    = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_row[c]   = '0;
      inject_y[c] = '0;
    end

    // Outputs gated low while in reset even with in_valid high.
    @(posedge clk); #1;
    half_neg();
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_core_valid_in", int'(core_valid_in), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_err", int'(err), 0);
    half_pos();
    do_reset();

    // Identity block: columns {k, 8+k, ..., 56+k}.
    $display("[TB] identity block");
    apply_stimulus(8, 1'b0);
    check_output("identity_cols", 8, 60);
    chk("identity_err", int'(err), 0);
    chk("identity_queue_empty", exp_q.size(), 0);

    // Continuous three blocks with fixed handshake timing.
    $display("[TB] continuous three blocks");
    do_reset();
    apply_stimulus(24, 1'b1);
    for (int t = 0; t < 48; t++) begin
      half_neg();
      if (t <= 27) chk($sformatf("cont_in_ready_t%0d", t), int'(in_ready), int'(!(t >= 16 && t <= 19)));
      chk($sformatf("cont_out_valid_t%0d", t), int'(out_valid),
          int'((t >= 12 && t <= 27) || (t >= 32 && t <= 39)));
      chk($sformatf("cont_out_last_t%0d", t), int'(out_last), int'(t == 19 || t == 27 || t == 39));
      half_pos();
    end
    chk("cont_queue_empty", exp_q.size(), 0);
    chk("cont_err", int'(err), 0);

    // Back-pressure: hold column 0 of block 0 for 30 cycles.
    $display("[TB] back-pressure");
    do_reset();
    out_ready = 1'b0;
    apply_stimulus(24, 1'b1);
    budget = 40;
    while (!out_valid && budget > 0) begin
      run(1);
      budget--;
    end
    chk("bp_out_valid_rise", int'(out_valid), 1);
    for (int i = 0; i < 30; i++) begin
      bit same;
      half_neg();
      same = (exp_q.size() > 0);
      for (int r = 0; r < 8; r++) begin
        if (exp_q.size() > 0 && out_col[r] !== exp_q[0].col[r]) same = 1'b0;
      end
      chk("bp_hold_idx", int'(out_col_idx), 0);
      chk("bp_hold_col", int'(same), 1);
      half_pos();
    end
    half_neg();
    chk("bp_in_ready_blocked", int'(in_ready), 0);
    chk("bp_rows_pending", rows_left, 8);
    half_pos();
    out_ready = 1'b1;
    check_output("bp_cols", 24, 200);
    run(5);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset after five rows: partial block discarded, fresh block works.
    $display("[TB] reset mid-block");
    do_reset();
    apply_stimulus(8, 1'b1);
    run(5);
    chk("mid_rows_sent", rows_left, 3);
    rst       = 1'b1;
    rows_left = 0;
    in_valid  = 1'b0;
    run(1);
    rst = 1'b0;
    half_neg();
    chk("mid_in_ready", int'(in_ready), 1);
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_err", int'(err), 0);
    half_pos();
    apply_stimulus(8, 1'b1);
    check_output("mid_fresh_cols", 8, 60);
    run(12);
    chk("mid_queue_empty", exp_q.size(), 0);

    // Spurious core result with both banks FREE.
    $display("[TB] spurious core result");
    do_reset();
    for (int c = 0; c < 8; c++) inject_y[c] = CW'($urandom);
    inject = 1'b1;
    run(1);
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half_neg();
      chk("spur_err_sticky", int'(err), 1);
      chk("spur_out_valid", int'(out_valid), 0);
      chk("spur_in_ready", int'(in_ready), 1);
      half_pos();
    end
    apply_stimulus(8, 1'b1);
    check_output("spur_cols", 8, 60);
    chk("spur_err_after_block", int'(err), 1);
    do_reset();
    half_neg();
    chk("spur_err_cleared", int'(err), 0);
    half_pos();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
